// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory access unit.
// Lane numbering follows the configured endianness; all helpers work on 32-bit words.
package mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic size_e size_of(input logic mem_byte, input logic mem_half);
    size_e sz;
    if (mem_byte) begin
      sz = SZ_BYTE;
    end else if (mem_half) begin
      sz = SZ_HALF;
    end else begin
      sz = SZ_WORD;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] off,
                                             input logic big_endian);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = big_endian ? (4'b1000 >> off) : (4'b0001 << off);
      SZ_HALF: be = (off[1] ^ big_endian) ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Pulls the addressed byte/half out of the read word and widens it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input size_e sz,
                                          input logic [1:0] off, input logic sign_ext,
                                          input logic big_endian);
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lane = big_endian ? ~off : off;
    b    = word[{lane, 3'b000} +: 8];
    h    = (off[1] ^ big_endian) ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data replication and byte enables on the request side,
// addressed-lane extraction with sign/zero extension on the response side.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_sign_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  size_e st_size;
  size_e ld_size;

  assign st_size = size_e'(st_size_i);
  assign ld_size = size_e'(ld_size_i);

  always_comb begin
    st_wdata_o = st_data_i;
    case (st_size)
      SZ_BYTE: st_wdata_o = {4{st_data_i[7:0]}};
      SZ_HALF: st_wdata_o = {2{st_data_i[15:0]}};
      default: st_wdata_o = st_data_i;
    endcase
  end

  assign st_be_o   = byte_enable(st_size, st_off_i, BIG_ENDIAN);
  assign ld_data_o = extract(ld_word_i, ld_size, ld_off_i, ld_sign_i, BIG_ENDIAN);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ack sequencing, stall, lane steering,
// LL/SC link tracking, misalignment and bus-timeout reporting into the MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_half,
  input  logic              mem_byte,
  input  logic              mem_sign_extend,
  input  logic              llsc,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       read_data2,
  input  logic [4:0]        reg_dst,
  input  logic              ll_clear,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_reg_dst,
  output logic [31:0]       wb_data,
  output logic              addr_err,
  output logic              bus_err
);

  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                link_q, link_d;
  logic [ADDR_W-3:0]   link_addr_q, link_addr_d;

  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic                sx_q, sx_d;
  logic                m2r_q, m2r_d;
  logic                rw_q, rw_d;
  logic                llsc_q, llsc_d;
  logic [4:0]          dst_q, dst_d;
  logic [31:0]         alu_q, alu_d;

  logic                wb_valid_q, wb_valid_d;
  logic                wb_rw_q, wb_rw_d;
  logic [4:0]          wb_dst_q, wb_dst_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                aerr_q, aerr_d;
  logic                berr_q, berr_d;

  logic                stall_c;
  size_e               in_size;
  logic                mem_op;
  logic                is_sc;
  logic                misaligned;
  logic                sc_fail;
  logic                timeout_hit;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic [31:0]         ld_data;

  assign in_size    = size_of(mem_byte, mem_half);
  assign mem_op     = valid & (mem_read | mem_write);
  assign is_sc      = llsc & mem_write;
  assign misaligned = is_misaligned(in_size, alu_result[1:0]);
  assign sc_fail    = is_sc & (~link_q | (link_addr_q != alu_result[ADDR_W-1:2]));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST)) && !dm_ack;

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_align (
    .st_size_i (in_size),
    .st_off_i  (alu_result[1:0]),
    .st_data_i (read_data2),
    .st_be_o   (st_be),
    .st_wdata_o(st_wdata),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .ld_sign_i (sx_q),
    .ld_word_i (dm_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    link_d      = link_q;
    link_addr_d = link_addr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    sx_d        = sx_q;
    m2r_d       = m2r_q;
    rw_d        = rw_q;
    llsc_d      = llsc_q;
    dst_d       = dst_q;
    alu_d       = alu_q;
    wb_valid_d  = 1'b0;
    wb_rw_d     = 1'b0;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    aerr_d      = 1'b0;
    berr_d      = 1'b0;
    stall_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_valid_d = valid;
        wb_rw_d    = reg_write & valid;
        wb_dst_d   = reg_dst;
        wb_data_d  = alu_result;
        if (mem_op) begin
          if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = 1'b0;
            aerr_d     = 1'b1;
          end else if (sc_fail) begin
            wb_rw_d   = 1'b1;
            wb_data_d = 32'd0;
          end else begin
            stall_c    = 1'b1;
            state_d    = ST_BUSY;
            req_d      = 1'b1;
            we_d       = mem_write;
            addr_d     = {alu_result[ADDR_W-1:2], 2'b00};
            be_d       = st_be;
            wdata_d    = st_wdata;
            size_d     = in_size;
            off_d      = alu_result[1:0];
            sx_d       = mem_sign_extend;
            m2r_d      = mem_to_reg;
            rw_d       = reg_write;
            llsc_d     = llsc;
            dst_d      = reg_dst;
            alu_d      = alu_result;
            wb_valid_d = 1'b0;
            wb_rw_d    = 1'b0;
          end
          // Any SC consumes the link, whether it succeeds, fails or faults.
          if (is_sc) begin
            link_d = 1'b0;
          end
        end
      end

      ST_BUSY: begin
        if (dm_ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_dst_d   = dst_q;
          wb_rw_d    = rw_q;
          if (we_q) begin
            wb_data_d = alu_q;
            if (llsc_q) begin
              wb_rw_d   = 1'b1;
              wb_data_d = 32'd1;
            end else if (link_q && (link_addr_q == addr_q[ADDR_W-1:2])) begin
              link_d = 1'b0;
            end
          end else begin
            wb_data_d = m2r_q ? ld_data : alu_q;
            if (llsc_q) begin
              link_d      = 1'b1;
              link_addr_d = addr_q[ADDR_W-1:2];
            end
          end
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_dst_d   = dst_q;
          berr_d     = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (ll_clear) begin
      link_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      link_q      <= 1'b0;
      link_addr_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      sx_q        <= 1'b0;
      m2r_q       <= 1'b0;
      rw_q        <= 1'b0;
      llsc_q      <= 1'b0;
      dst_q       <= '0;
      alu_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dst_q    <= '0;
      wb_data_q   <= '0;
      aerr_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      link_q      <= link_d;
      link_addr_q <= link_addr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sx_q        <= sx_d;
      m2r_q       <= m2r_d;
      rw_q        <= rw_d;
      llsc_q      <= llsc_d;
      dst_q       <= dst_d;
      alu_q       <= alu_d;
      wb_valid_q  <= wb_valid_d;
      wb_rw_q     <= wb_rw_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
      aerr_q      <= aerr_d;
      berr_q      <= berr_d;
    end
  end

  // Stall is masked during reset so the pipeline is released as soon as the unit is.
  assign stall        = stall_c & rst_n;
  assign dm_req       = req_q;
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_be        = be_q;
  assign dm_wdata     = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_reg_dst   = wb_dst_q;
  assign wb_data      = wb_data_q;
  assign addr_err     = aerr_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a big-endian and a little-endian instance share one stimulus stream;
// a vector table covers loads/stores/misalignment, hand sequences cover LL/SC, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid, mem_read, mem_write, mem_half, mem_byte, mem_sign_extend;
  logic        llsc, reg_write, mem_to_reg, ll_clear, dm_ack;
  logic [31:0] alu_result, read_data2, dm_rdata;
  logic [4:0]  reg_dst;

  logic        dm_req_b, dm_we_b, stall_b, wb_valid_b, wb_rw_b, aerr_b, berr_b;
  logic [31:0] dm_addr_b, dm_wdata_b, wb_data_b;
  logic [3:0]  dm_be_b;
  logic [4:0]  wb_dst_b;
  logic        dm_req_l, dm_we_l, stall_l, wb_valid_l, wb_rw_l, aerr_l, berr_l;
  logic [31:0] dm_addr_l, dm_wdata_l, wb_data_l;
  logic [3:0]  dm_be_l;
  logic [4:0]  wb_dst_l;

  int n_checks = 0;
  int n_err = 0;

  int          c_stall, c_req;
  logic        c_hang, c_we, c_wbv, c_wbrw, c_aerr, c_berr;
  logic [3:0]  c_be_b, c_be_l;
  logic [31:0] c_wd_b, c_wd_l, c_addr, c_wb_b, c_wb_l;
  logic [4:0]  c_dst;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_half(mem_half), .mem_byte(mem_byte), .mem_sign_extend(mem_sign_extend),
    .llsc(llsc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_result(alu_result), .read_data2(read_data2), .reg_dst(reg_dst),
    .ll_clear(ll_clear), .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b),
    .dm_be(dm_be_b), .dm_wdata(dm_wdata_b), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall_b), .wb_valid(wb_valid_b), .wb_reg_write(wb_rw_b),
    .wb_reg_dst(wb_dst_b), .wb_data(wb_data_b), .addr_err(aerr_b), .bus_err(berr_b)
  );

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_half(mem_half), .mem_byte(mem_byte), .mem_sign_extend(mem_sign_extend),
    .llsc(llsc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_result(alu_result), .read_data2(read_data2), .reg_dst(reg_dst),
    .ll_clear(ll_clear), .dm_req(dm_req_l), .dm_we(dm_we_l), .dm_addr(dm_addr_l),
    .dm_be(dm_be_l), .dm_wdata(dm_wdata_l), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall_l), .wb_valid(wb_valid_l), .wb_reg_write(wb_rw_l),
    .wb_reg_dst(wb_dst_l), .wb_data(wb_data_l), .addr_err(aerr_l), .bus_err(berr_l)
  );

  typedef struct {
    string       nm;
    logic        rd, wr, hf, by, sx, rw, m2r;
    logic [31:0] a, wd, rdat;
    int          k;
    int          e_stall, e_req;
    logic        e_we;
    logic [3:0]  e_be_b, e_be_l;
    logic [31:0] e_wdata, e_addr;
    logic        chk_d;
    logic [31:0] e_wb_b, e_wb_l;
    logic        e_rw, e_aerr;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_half = 1'b0; mem_byte = 1'b0;
    mem_sign_extend = 1'b0; llsc = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    alu_result = 32'h0; read_data2 = 32'h0; reg_dst = 5'd0; ll_clear = 1'b0;
  endtask

  // Presents one EX/MEM instruction, acks on BUSY cycle k (k=0: never), captures the result.
  task automatic run_op(input logic rd, input logic wr, input logic hf, input logic by,
                        input logic sx, input logic ll, input logic rw, input logic m2r,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int k);
    @(posedge clk); #1;
    valid = 1'b1; mem_read = rd; mem_write = wr; mem_half = hf; mem_byte = by;
    mem_sign_extend = sx; llsc = ll; reg_write = rw; mem_to_reg = m2r;
    alu_result = a; read_data2 = wd; dm_rdata = rdat; reg_dst = 5'd9; dm_ack = 1'b0;
    c_stall = 0; c_req = 0; c_hang = 1'b0; c_we = 1'b0;
    c_be_b = 4'h0; c_be_l = 4'h0; c_wd_b = 32'h0; c_wd_l = 32'h0; c_addr = 32'h0;
    #1;
    if (stall_b) c_stall++;
    if (dm_req_b) c_req++;
    if (stall_b) begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin
          c_be_b = dm_be_b; c_be_l = dm_be_l; c_wd_b = dm_wdata_b; c_wd_l = dm_wdata_l;
          c_addr = dm_addr_b; c_we = dm_we_b;
        end
        dm_ack = (i == k);
        #1;
        if (dm_req_b) c_req++;
        if (!stall_b) break;
        c_stall++;
        if (i == 40) c_hang = 1'b1;
      end
    end
    @(posedge clk); #1;
    dm_ack = 1'b0;
    clear_in();
    #1;
    c_wbv = wb_valid_b; c_wbrw = wb_rw_b; c_aerr = aerr_b; c_berr = berr_b;
    c_wb_b = wb_data_b; c_wb_l = wb_data_l; c_dst = wb_dst_b;
    $display("op addr=0x%08h rd=%0b wr=%0b ll=%0b req_cycles=%0d stall_cycles=%0d wb_be=0x%08h wb_le=0x%08h aerr=%0b berr=%0b",
             a, rd, wr, ll, c_req, c_stall, c_wb_b, c_wb_l, c_aerr, c_berr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          nm           rd   wr   hf   by   sx   rw   m2r  addr        wdata         rdata         k  stl req we   be_b     be_l     exp_wdata     exp_addr     chk_d wb_be         wb_le         rw   aerr
    vt[0]  = '{"lb_sx",      1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00001001,32'h00000000,32'h11F23344,3, 3, 3, 1'b0,4'b0100,4'b0010,32'h00000000,32'h00001000,1'b1,32'hFFFFFFF2,32'h00000033,1'b1,1'b0};
    vt[1]  = '{"sh_2002",    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h00002002,32'h0000ABCD,32'h00000000,1, 1, 1, 1'b1,4'b0011,4'b1100,32'hABCDABCD,32'h00002000,1'b0,32'h0,        32'h0,        1'b0,1'b0};
    vt[2]  = '{"lw_mis",     1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h00003002,32'h00000000,32'h00000000,1, 0, 0, 1'b0,4'b0000,4'b0000,32'h0,        32'h0,        1'b0,32'h0,        32'h0,        1'b0,1'b1};
    vt[3]  = '{"lhu_5002",   1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,32'h00005002,32'h00000000,32'h8899AABB,2, 2, 2, 1'b0,4'b0011,4'b1100,32'h00000000,32'h00005000,1'b1,32'h0000AABB,32'h00008899,1'b1,1'b0};
    vt[4]  = '{"lh_5000",    1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,32'h00005000,32'h00000000,32'h8899AABB,1, 1, 1, 1'b0,4'b1100,4'b0011,32'h00000000,32'h00005000,1'b1,32'hFFFF8899,32'hFFFFAABB,1'b1,1'b0};
    vt[5]  = '{"lw_6004",   1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h00006004,32'h00000000,32'hDEADBEEF,2, 2, 2, 1'b0,4'b1111,4'b1111,32'h00000000,32'h00006004,1'b1,32'hDEADBEEF,32'hDEADBEEF,1'b1,1'b0};
    vt[6]  = '{"sb_7003",    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h00007003,32'h000000A5,32'h00000000,1, 1, 1, 1'b1,4'b0001,4'b1000,32'hA5A5A5A5,32'h00007000,1'b0,32'h0,        32'h0,        1'b0,1'b0};
    vt[7]  = '{"passthru",   1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h12345678,32'h00000000,32'h00000000,1, 0, 0, 1'b0,4'b0000,4'b0000,32'h0,        32'h0,        1'b1,32'h12345678,32'h12345678,1'b1,1'b0};
    vt[8]  = '{"lbu_1003",   1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h00001003,32'h00000000,32'h11F23344,1, 1, 1, 1'b0,4'b0001,4'b1000,32'h00000000,32'h00001000,1'b1,32'h00000044,32'h00000011,1'b1,1'b0};
    vt[9]  = '{"sh_mis",     1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h00002001,32'h00001234,32'h00000000,1, 0, 0, 1'b0,4'b0000,4'b0000,32'h0,        32'h0,        1'b0,32'h0,        32'h0,        1'b0,1'b1};
    vt[10] = '{"sw_ack_at_to",1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00008008,32'hCAFEF00D,32'h00000000,4, 4, 4, 1'b1,4'b1111,4'b1111,32'hCAFEF00D,32'h00008008,1'b0,32'h0,        32'h0,        1'b0,1'b0};

    clear_in();
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", {31'h0, dm_req_b}, 32'h0);
    chk("rst_dm_we", {31'h0, dm_we_b}, 32'h0);
    chk("rst_dm_be", {28'h0, dm_be_b}, 32'h0);
    chk("rst_dm_addr", dm_addr_b, 32'h0);
    chk("rst_dm_wdata", dm_wdata_b, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid_b}, 32'h0);
    chk("rst_wb_reg_write", {31'h0, wb_rw_b}, 32'h0);
    chk("rst_wb_data", wb_data_b, 32'h0);
    chk("rst_errs", {30'h0, aerr_b, berr_b}, 32'h0);
    chk("rst_stall", {31'h0, stall_b}, 32'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run_op(vt[v].rd, vt[v].wr, vt[v].hf, vt[v].by, vt[v].sx, 1'b0, vt[v].rw, vt[v].m2r,
             vt[v].a, vt[v].wd, vt[v].rdat, vt[v].k);
      chk({vt[v].nm, "_hang"}, {31'h0, c_hang}, 32'h0);
      chk({vt[v].nm, "_stall_cycles"}, c_stall, vt[v].e_stall);
      chk({vt[v].nm, "_req_cycles"}, c_req, vt[v].e_req);
      chk({vt[v].nm, "_wb_valid"}, {31'h0, c_wbv}, 32'h1);
      chk({vt[v].nm, "_wb_reg_write"}, {31'h0, c_wbrw}, {31'h0, vt[v].e_rw});
      chk({vt[v].nm, "_wb_reg_dst"}, {27'h0, c_dst}, 32'd9);
      chk({vt[v].nm, "_addr_err"}, {31'h0, c_aerr}, {31'h0, vt[v].e_aerr});
      chk({vt[v].nm, "_bus_err"}, {31'h0, c_berr}, 32'h0);
      if (vt[v].e_req > 0) begin
        chk({vt[v].nm, "_dm_we"}, {31'h0, c_we}, {31'h0, vt[v].e_we});
        chk({vt[v].nm, "_dm_addr"}, c_addr, vt[v].e_addr);
        chk({vt[v].nm, "_dm_be_big"}, {28'h0, c_be_b}, {28'h0, vt[v].e_be_b});
        chk({vt[v].nm, "_dm_be_little"}, {28'h0, c_be_l}, {28'h0, vt[v].e_be_l});
        chk({vt[v].nm, "_dm_wdata_big"}, c_wd_b, vt[v].e_wdata);
        chk({vt[v].nm, "_dm_wdata_little"}, c_wd_l, vt[v].e_wdata);
      end
      if (vt[v].chk_d) begin
        chk({vt[v].nm, "_wb_data_big"}, c_wb_b, vt[v].e_wb_b);
        chk({vt[v].nm, "_wb_data_little"}, c_wb_l, vt[v].e_wb_l);
      end
      @(posedge clk); #2;
      chk({vt[v].nm, "_pulse_clear"}, {30'h0, aerr_b, berr_b}, 32'h0);
    end

    // LL then SC to the same word succeeds; a second SC fails without a request.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 32'h0, 32'h13572468, 1);
    chk("ll_req", c_req, 32'd1);
    chk("ll_wb_data", c_wb_b, 32'h13572468);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h55, 32'h0, 1);
    chk("sc1_req", c_req, 32'd1);
    chk("sc1_we", {31'h0, c_we}, 32'h1);
    chk("sc1_wb_data", c_wb_b, 32'd1);
    chk("sc1_wb_reg_write", {31'h0, c_wbrw}, 32'h1);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h66, 32'h0, 1);
    chk("sc2_req", c_req, 32'd0);
    chk("sc2_stall", c_stall, 32'd0);
    chk("sc2_wb_data", c_wb_b, 32'd0);
    chk("sc2_wb_reg_write", {31'h0, c_wbrw}, 32'h1);

    // ll_clear between LL and SC kills the link.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 32'h0, 32'h0, 1);
    @(posedge clk); #1 ll_clear = 1'b1;
    @(posedge clk); #1 ll_clear = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h77, 32'h0, 1);
    chk("sc_after_clear_req", c_req, 32'd0);
    chk("sc_after_clear_wb_data", c_wb_b, 32'd0);

    // A store to a different word keeps the link; a store to the linked word clears it.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 32'h0, 32'h0, 1);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4004, 32'h1, 32'h0, 1);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h88, 32'h0, 1);
    chk("sc_other_store_req", c_req, 32'd1);
    chk("sc_other_store_wb_data", c_wb_b, 32'd1);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 32'h0, 32'h0, 1);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000, 32'h2, 32'h0, 1);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h99, 32'h0, 1);
    chk("sc_same_store_req", c_req, 32'd0);
    chk("sc_same_store_wb_data", c_wb_b, 32'd0);

    // No ack ever: request held TIMEOUT cycles, then bus error.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000, 32'h0, 32'h0, 0);
    chk("to_hang", {31'h0, c_hang}, 32'h0);
    chk("to_req_cycles", c_req, 32'd4);
    chk("to_stall_cycles", c_stall, 32'd4);
    chk("to_bus_err", {31'h0, c_berr}, 32'h1);
    chk("to_wb_valid", {31'h0, c_wbv}, 32'h1);
    chk("to_wb_reg_write", {31'h0, c_wbrw}, 32'h0);
    @(posedge clk); #2;
    chk("to_bus_err_pulse", {31'h0, berr_b}, 32'h0);
    chk("to_req_idle", {31'h0, dm_req_b}, 32'h0);

    // Reset asserted mid-BUSY abandons the transaction immediately.
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; alu_result = 32'h9000;
    @(posedge clk); #2;
    chk("rb_req_busy", {31'h0, dm_req_b}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rb_req_drop", {31'h0, dm_req_b}, 32'h0);
    chk("rb_stall_drop", {31'h0, stall_b}, 32'h0);
    chk("rb_wb_valid", {31'h0, wb_valid_b}, 32'h0);
    @(posedge clk); #1;
    clear_in();
    rst_n = 1'b1;
    #1;
    chk("rb_wb_reg_write", {31'h0, wb_rw_b}, 32'h0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000A5A5, 32'h0, 32'h0, 1);
    chk("rb_pass_stall", c_stall, 32'd0);
    chk("rb_pass_wb_data", c_wb_b, 32'h0000A5A5);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9000, 32'h0, 32'h0BADF00D, 1);
    chk("rb_lw_req", c_req, 32'd1);
    chk("rb_lw_wb_data", c_wb_b, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MEM-stage data-memory access unit for the MIPS III pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns EX/MEM load/store control into a request/acknowledge transaction on the D-memory port, with stall generation, byte/half lane steering, sign extension, LL/SC link tracking, misalignment detection and a bus timeout. Successor to the flat MEM signal bundle: it adds configurable address width, endianness, wait-state tolerance and real LL/SC semantics.

## Interface
- ADDR_W, 32, D-memory address width (≥ 3); alu_result[ADDR_W-1:0] is the address.
- BIG_ENDIAN, 1, lane order: 1 → offset 0 is bits[31:24]; 0 → offset 0 is bits[7:0].
- TIMEOUT, 16, BUSY cycles without dm_ack before bus error; 0 disables the timeout.
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  EX/MEM holds a live instruction.
- mem_read, mem_write, mem_half, mem_byte, mem_sign_extend, llsc, reg_write, mem_to_reg  in  1 each  EX/MEM control.
- alu_result  in  32  address or pass-through result.
- read_data2  in  32  store data.
- reg_dst  in  5  destination register.
- ll_clear  in  1  exception/ERET; clears the link.
- dm_req  out  1  request, held until dm_ack or timeout.
- dm_we  out  1  write.
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  request complete; dm_rdata valid this cycle.
- dm_rdata  in  32  read word.
- stall  out  1  hold EX/MEM and upstream.
- wb_valid, wb_reg_write  out  1 each  MEM/WB control.
- wb_reg_dst  out  5  MEM/WB destination.
- wb_data  out  32  MEM/WB result.
- addr_err, bus_err  out  1 each  one-cycle pulses, aligned with wb_valid.

## Operation
- States: IDLE, BUSY.
- mem_op = valid & (mem_read | mem_write).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, no mem_op: stall=0. The WB registers load the pass-through next edge: wb_data=alu_result, wb_reg_write=reg_write&valid.
- IDLE, misaligned mem_op:
  - No request and no stall.
  - Next edge: wb_valid=1, wb_reg_write=0, addr_err=1.
- IDLE, failing SC (llsc & mem_write, and link=0 or link_addr≠addr[ADDR_W-1:2]):
  - No request and no stall.
  - Next edge: wb_reg_write=1, wb_data=0.
  - Link cleared.
- IDLE, otherwise mem_op:
  - stall=1.
  - Latch dm_addr/dm_be/dm_wdata/dm_we and the op.
  - → BUSY.
- BUSY: dm_req=1, outputs stable. stall = ~dm_ack & ~timeout_hit.
  - On dm_ack → IDLE.
    - Loads: wb_data = lane-extracted dm_rdata, zero- or sign-extended per mem_sign_extend when mem_to_reg, else alu_result.
    - Successful SC: wb_data=1.
  - On timeout_hit (counter = TIMEOUT-1, no ack): dm_req drops, → IDLE, bus_err=1, wb_reg_write=0.
  - dm_ack and timeout_hit in the same cycle: ack wins.
- Store lanes:
  - byte: read_data2[7:0] replicated ×4.
  - half: read_data2[15:0] replicated ×2.
  - dm_be per offset and BIG_ENDIAN; word uses 4'b1111.
- LL completion sets link=1 and link_addr=addr[ADDR_W-1:2].
- Link clears on:
  - any SC,
  - any completed store to the linked word,
  - ll_clear.
- ll_clear in the same cycle as LL completion: clear wins.
- rst_n mid-BUSY: transaction abandoned, no WB write, dm_req drops immediately.

## Timing
- Reset values:
  - state=IDLE, link=0, link_addr=0, counter=0.
  - dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0.
  - all wb_* and error outputs 0.
- stall is combinational from the state and inputs (same cycle).
- Pass-through, misaligned and failing-SC ops: WB output one edge after the input cycle.
- Memory op, ack after k≥1 BUSY cycles: acceptance cycle plus k BUSY cycles with stall high except the ack cycle. WB output on the edge ending the ack cycle. Minimum occupancy is 2 cycles.
- dm_ack is ignored in IDLE.

## Structure
- Package mem_pkg holds:
  - state enum,
  - access-size enum (BYTE/HALF/WORD),
  - functions for byte-enable generation and lane extraction with extension (parametrised by endianness).
- Sub-module mem_lane_align (combinational) performs:
  - store replication and dm_be,
  - load extraction and sign/zero extension.
- The FSM, timeout counter and link register live in mem_access_unit.

## Test plan
- lb, BIG_ENDIAN=1, addr 0x1001, dm_rdata 0x11F233_44, sign-extend, ack after 3 cycles → stall for 3 cycles, wb_data=0xFFFFFFF2.
- sh, addr 0x2002, read_data2 0x0000ABCD, BIG_ENDIAN=0 → dm_be=4'b1100, dm_wdata=0xABCDABCD, dm_addr=0x2000.
- lw at 0x3002 → no dm_req, addr_err pulse, wb_reg_write=0, stall never high.
- LL 0x4000, then SC 0x4000 → SC store issued, wb_data=1. Second SC → no request, wb_data=0. LL, then ll_clear, then SC → wb_data=0.
- TIMEOUT=4, dm_ack never arrives → dm_req high exactly 4 cycles, bus_err pulse, stall drops.
- rst_n low during BUSY → dm_req, stall and wb_valid 0 within the same cycle; IDLE after release.
